// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - N-to-1 registered mux with direct and round-robin scan modes
module mux_scan_sel #(
  parameter  int SEL_W  = 5,
  parameter  int DATA_W = 1,
  localparam int N      = 2 ** SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N-1:0]        en_mask,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic [N-1:0]        out_onehot,
  output logic                out_last
);

  logic             load;
  logic [SEL_W-1:0] ptr;

  logic [2*N-1:0]   dbl_mask;
  logic [N-1:0]     rot_mask;
  logic             scan_hit;
  logic [SEL_W-1:0] scan_off;
  logic [SEL_W-1:0] scan_idx;
  logic [N-1:0]     upper_mask;
  logic             scan_last;

  logic             nxt_valid;
  logic [DATA_W-1:0] nxt_data;
  logic [SEL_W-1:0] nxt_sel;
  logic [N-1:0]     nxt_onehot;
  logic             nxt_last;
  logic [SEL_W-1:0] nxt_ptr;

  // A held sample is only replaced once downstream has taken it.
  assign load = ~out_valid | out_ready;

  // Rotate the mask so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    dbl_mask = {en_mask, en_mask} >> ptr;
    rot_mask = dbl_mask[N-1:0];
    scan_hit = 1'b0;
    scan_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_mask[i]) begin
        scan_hit = 1'b1;
        scan_off = i[SEL_W-1:0];
      end
    end
    scan_idx   = ptr + scan_off;
    upper_mask = en_mask >> scan_idx;
    scan_last  = (upper_mask >> 1) == '0;
  end

  // Next-sample selection; everything holds unless this is a load edge.
  always_comb begin
    nxt_valid  = out_valid;
    nxt_data   = out_data;
    nxt_sel    = out_sel;
    nxt_onehot = out_onehot;
    nxt_last   = out_last;
    nxt_ptr    = ptr;
    if (load) begin
      if (!mode) begin
        nxt_sel    = sel;
        nxt_data   = in_data[sel*DATA_W +: DATA_W];
        nxt_valid  = en_mask[sel];
        nxt_onehot = en_mask[sel] ? (N'(1) << sel) : '0;
        nxt_last   = 1'b0;
      end else if (scan_hit) begin
        nxt_sel    = scan_idx;
        nxt_data   = in_data[scan_idx*DATA_W +: DATA_W];
        nxt_valid  = 1'b1;
        nxt_onehot = N'(1) << scan_idx;
        nxt_last   = scan_last;
        nxt_ptr    = scan_idx + 1'b1;
      end else begin
        nxt_valid  = 1'b0;
        nxt_onehot = '0;
        nxt_last   = 1'b0;
      end
    end
  end

  // Output register stage and scan pointer; reset discards any held sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      out_onehot <= '0;
      out_last   <= 1'b0;
      ptr        <= '0;
    end else begin
      out_valid  <= nxt_valid;
      out_data   <= nxt_data;
      out_sel    <= nxt_sel;
      out_onehot <= nxt_onehot;
      out_last   <= nxt_last;
      ptr        <= nxt_ptr;
    end
  end

endmodule
